// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter family.
package ram_arb_pkg;

  // Largest requester count any arbiter in this family supports.
  localparam int CReqCntMax = 8;
  // Index width that covers CReqCntMax requesters.
  localparam int CIdxW = 3;
  // Lock counter width; CLockMax is limited to 255.
  localparam int CLockCntW = 8;

  // Registered burst-lock state: owner, valid flag and consecutive grant count.
  typedef struct packed {
    logic                 vld;
    logic [CIdxW-1:0]     own;
    logic [CLockCntW-1:0] cnt;
  } lock_t;

  // One-hot vector with bit idx set; all zero when idx is outside [0, n).
  function automatic logic [CReqCntMax-1:0] OneHot(input int idx, input int n);
    logic [CReqCntMax-1:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < CReqCntMax) v = CReqCntMax'(1) << idx;
    return v;
  endfunction

  // Pointer width for n requesters, never less than one bit.
  function automatic int ClogB(input int n);
    int w;
    w = 1;
    for (int k = 1; k <= 16; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo N, so the requester at ptr_i itself is considered last.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand;

  // Walk the requesters from ptr_i+1 and take the first active one.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
        gnt_o = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/ram_sx_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// CReqCnt requesters, with bounded burst locking and tagged read return.
//
// Handshake: a requester raises AReqWrEn and/or AReqRdEn with address and
// data and holds all of them stable until it sees AReqAck for one cycle;
// the command is accepted in that same cycle. Read data comes back one
// enabled cycle later on AReqMiso, qualified by the one-hot AReqMisoVld.
module ram_sx_arb
  import ram_arb_pkg::*;
#(
  parameter int CReqCnt  = 4,
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CLockMax = 8
) (
  input  logic                         AClkH,
  input  logic                         AResetH,
  input  logic                         AClkHEn,
  input  logic [CReqCnt*CAddrLen-1:0]  AReqAddr,
  input  logic [CReqCnt*CDataLen-1:0]  AReqMosi,
  input  logic [CReqCnt-1:0]           AReqWrEn,
  input  logic [CReqCnt-1:0]           AReqRdEn,
  input  logic [CReqCnt-1:0]           AReqLock,
  output logic [CReqCnt-1:0]           AReqAck,
  output logic [CDataLen-1:0]          AReqMiso,
  output logic [CReqCnt-1:0]           AReqMisoVld,
  output logic [CAddrLen-1:0]          ARamAddr,
  output logic [CDataLen-1:0]          ARamMosi,
  output logic                         ARamWrEn,
  output logic                         ARamRdEn,
  input  logic [CDataLen-1:0]          ARamMiso
);

  localparam int PW = ClogB(CReqCnt);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CReqCnt-1:0] vld_q, vld_d;
  lock_t              lock_q, lock_d;

  logic [CReqCnt-1:0] active;
  logic [CReqCnt-1:0] rr_gnt;
  logic [PW-1:0]      rr_idx;
  logic               rr_any;

  logic [PW-1:0]      lock_sel;
  logic               lock_hit;
  logic               gnt_any;
  logic [PW-1:0]      gnt_idx;
  logic [CReqCnt-1:0] gnt_vec;
  logic               gnt_rd;
  logic               gnt_wr;
  logic               gnt_lock;
  logic               fire;
  logic [PW-1:0]      mux_sel;

  assign active = AReqWrEn | AReqRdEn;

  rr_pick #(
    .N  (CReqCnt),
    .PW (PW)
  ) u_rr_pick (
    .req_i (active),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx),
    .any_o (rr_any)
  );

  // Grant selection: a live lock under its limit wins, otherwise round-robin.
  always_comb begin
    lock_sel = PW'(lock_q.own);
    lock_hit = lock_q.vld && active[lock_sel] &&
               (lock_q.cnt < CLockCntW'(CLockMax));
    gnt_any  = lock_hit | rr_any;
    gnt_idx  = lock_hit ? lock_sel : rr_idx;
    gnt_vec  = lock_hit ? CReqCnt'(OneHot(int'(lock_sel), CReqCnt)) : rr_gnt;
    gnt_rd   = AReqRdEn[gnt_idx];
    gnt_wr   = AReqWrEn[gnt_idx];
    gnt_lock = AReqLock[gnt_idx];
    // An access only happens on an enabled cycle outside reset.
    fire     = gnt_any & AClkHEn & ~AResetH;
    // With nobody requesting, the RAM bus idles on requester 0.
    mux_sel  = gnt_any ? gnt_idx : '0;
  end

  // Drive acknowledge, RAM port and read return.
  always_comb begin
    AReqAck     = fire ? gnt_vec : '0;
    ARamAddr    = AReqAddr[int'(mux_sel)*CAddrLen +: CAddrLen];
    ARamMosi    = AReqMosi[int'(mux_sel)*CDataLen +: CDataLen];
    ARamWrEn    = fire & gnt_wr;
    ARamRdEn    = fire & gnt_rd;
    AReqMiso    = ARamMiso;
    AReqMisoVld = vld_q & {CReqCnt{AClkHEn}};
  end

  // Next state: pointer, read-valid tag and lock bookkeeping; all hold when disabled.
  always_comb begin
    ptr_d  = ptr_q;
    vld_d  = vld_q;
    lock_d = lock_q;
    if (AClkHEn) begin
      if (gnt_any) begin
        ptr_d = gnt_idx;
        vld_d = gnt_rd ? gnt_vec : '0;
        if (gnt_lock) begin
          lock_d.vld = 1'b1;
          lock_d.own = CIdxW'(gnt_idx);
          if (lock_q.vld && (lock_q.own == CIdxW'(gnt_idx))) begin
            lock_d.cnt = (lock_q.cnt < CLockCntW'(CLockMax)) ?
                         lock_q.cnt + CLockCntW'(1) : lock_q.cnt;
          end else begin
            lock_d.cnt = CLockCntW'(1);
          end
        end else begin
          lock_d = '0;
        end
      end else begin
        vld_d  = '0;
        lock_d = '0;
      end
    end
  end

  // State registers; reset points just below requester 0 so it wins first.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      ptr_q  <= PW'(CReqCnt - 1);
      vld_q  <= '0;
      lock_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: tb/tb_ram_sx_arb.sv
// Bench for ram_sx_arb: directed vector table plus randomized traffic
// checked against a behavioural arbiter/RAM model.
module tb_ram_sx_arb;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int LM = 4;
  localparam int NRAND = 400;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              en;
  logic [N*AW-1:0]   addr_v;
  logic [N*DW-1:0]   data_v;
  logic [N-1:0]      wr;
  logic [N-1:0]      rd;
  logic [N-1:0]      lk;
  logic [N-1:0]      ack;
  logic [DW-1:0]     miso;
  logic [N-1:0]      miso_vld;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_mosi;
  logic              ram_wr;
  logic              ram_rd;
  logic [DW-1:0]     ram_miso;

  ram_sx_arb #(
    .CReqCnt  (N),
    .CAddrLen (AW),
    .CDataLen (DW),
    .CLockMax (LM)
  ) dut (
    .AClkH       (clk),
    .AResetH     (rst),
    .AClkHEn     (en),
    .AReqAddr    (addr_v),
    .AReqMosi    (data_v),
    .AReqWrEn    (wr),
    .AReqRdEn    (rd),
    .AReqLock    (lk),
    .AReqAck     (ack),
    .AReqMiso    (miso),
    .AReqMisoVld (miso_vld),
    .ARamAddr    (ram_addr),
    .ARamMosi    (ram_mosi),
    .ARamWrEn    (ram_wr),
    .ARamRdEn    (ram_rd),
    .ARamMiso    (ram_miso)
  );

  // RamSX-style memory: read-before-write, registered data gated by registered read enable.
  bit [DW-1:0] mem [16];
  bit          mem_ok;
  bit          ram_rd_q;
  bit [DW-1:0] ram_dout_q;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
      mem_ok <= 1'b1;
    end else if (en) begin
      ram_rd_q <= ram_rd;
      if (ram_rd) ram_dout_q <= mem[ram_addr];
      if (ram_wr) mem[ram_addr] <= ram_mosi;
    end
  end
  assign ram_miso = ram_rd_q ? ram_dout_q : '0;

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      addr_v[i*AW +: AW] = p_addr[i];
      data_v[i*DW +: DW] = p_data[i];
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int            m_ptr;
  int            m_own;
  int            m_cnt;
  bit            m_lock;
  int            m_vld_idx;
  int            m_last_g;
  logic [DW-1:0] m_mem [16];
  logic [DW-1:0] exp_q [$];

  // Who should be served now, by the lock/round-robin rules; -1 if nobody.
  function automatic int m_pick();
    if (m_lock && (wr[m_own] | rd[m_own]) && m_cnt < LM) return m_own;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (wr[j] | rd[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_lock = 1'b0; m_cnt = 0; m_own = 0;
    m_vld_idx = -1; m_last_g = -1;
    exp_q.delete();
  endtask

  // Advance the model on a rising edge using the inputs held during the cycle.
  task automatic model_update();
    int g;
    if (rst) begin
      model_reset();
    end else if (en) begin
      g = m_pick();
      m_last_g = g;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (g < 0) begin
        m_vld_idx = -1; m_lock = 1'b0; m_cnt = 0;
      end else begin
        m_ptr = g;
        if (rd[g]) begin
          exp_q.push_back(m_mem[p_addr[g]]);
          m_vld_idx = g;
        end else begin
          m_vld_idx = -1;
        end
        if (wr[g]) m_mem[p_addr[g]] = p_data[g];
        if (lk[g]) begin
          if (m_lock && m_own == g) m_cnt = (m_cnt < LM) ? m_cnt + 1 : m_cnt;
          else m_cnt = 1;
          m_own = g; m_lock = 1'b1;
        end else begin
          m_lock = 1'b0; m_cnt = 0;
        end
      end
    end else begin
      m_last_g = -1;
    end
  endtask

  // Compare the DUT's combinational outputs against the model mid-cycle.
  task automatic model_check();
    int g;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_vld;
    logic [1:0]   e_en;
    g = m_pick();
    e_ack = '0; e_vld = '0; e_en = '0;
    if (!rst && en && g >= 0) begin
      e_ack = N'(1) << g;
      e_en  = {wr[g], rd[g]};
    end
    if (!rst && en && m_vld_idx >= 0) e_vld = N'(1) << m_vld_idx;
    check("rand_ack", 64'(ack), 64'(e_ack));
    check("rand_vld", 64'(miso_vld), 64'(e_vld));
    check("rand_ram_en", 64'({ram_wr, ram_rd}), 64'(e_en));
    if (e_vld != '0 && exp_q.size() > 0) check("rand_miso", 64'(miso), 64'(exp_q[0]));
    if (e_ack != '0) begin
      check("rand_ram_addr", 64'(ram_addr), 64'(p_addr[g]));
      if (wr[g]) check("rand_ram_mosi", 64'(ram_mosi), 64'(p_data[g]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            rst;
    bit            en;
    logic [N-1:0]  wr;
    logic [N-1:0]  rd;
    logic [N-1:0]  lk;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_vld;
    logic [DW-1:0] e_miso;
    logic [1:0]    e_ram_en;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit r, bit e, logic [3:0] w, logic [3:0] rr, logic [3:0] l,
                              logic [3:0] a, logic [15:0] d, logic [3:0] ea,
                              logic [3:0] ev, logic [15:0] em, logic [1:0] ee);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.rd = rr; v.lk = l; v.addr = a; v.data = d;
    v.e_ack = ea; v.e_vld = ev; v.e_miso = em; v.e_ram_en = ee;
    return v;
  endfunction

  task automatic fill_table();
    // reset with a write pending: nothing acknowledged, RAM idle
    vecs.push_back(mk(1,1,4'b0001,4'b0000,4'b0,4'd5,16'h00A5, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(1,1,4'b0001,4'b0000,4'b0,4'd5,16'h00A5, 4'b0000,4'b0000,16'h0,2'b00));
    // write/read round trip on addr 5
    vecs.push_back(mk(0,1,4'b0001,4'b0000,4'b0,4'd5,16'h00A5, 4'b0001,4'b0000,16'h0,2'b10));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h00A5, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,1,4'b0000,4'b0001,4'b0,4'd5,16'h00A5, 4'b0001,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h00A5, 4'b0000,4'b0001,16'h00A5,2'b00));
    // fairness from reset: 0,1,2,3,0 with tags trailing by one cycle
    vecs.push_back(mk(1,1,4'b0000,4'b0000,4'b0,4'd5,16'h0, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,1,4'b0000,4'b1111,4'b0,4'd5,16'h0, 4'b0001,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b1111,4'b0,4'd5,16'h0, 4'b0010,4'b0001,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b1111,4'b0,4'd5,16'h0, 4'b0100,4'b0010,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b1111,4'b0,4'd5,16'h0, 4'b1000,4'b0100,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b1111,4'b0,4'd5,16'h0, 4'b0001,4'b1000,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h0, 4'b0000,4'b0001,16'h00A5,2'b00));
    // lock limit 4: req1 locked burst vs req2
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0010,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0010,4'b0010,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0010,4'b0010,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0010,4'b0010,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0100,4'b0010,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0110,4'b0010,4'd5,16'h0, 4'b0010,4'b0100,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h0, 4'b0000,4'b0010,16'h00A5,2'b00));
    // read-before-write on addr 7
    vecs.push_back(mk(0,1,4'b1000,4'b0000,4'b0,4'd7,16'h0011, 4'b1000,4'b0000,16'h0,2'b10));
    vecs.push_back(mk(0,1,4'b1000,4'b1000,4'b0,4'd7,16'h0022, 4'b1000,4'b0000,16'h0,2'b11));
    vecs.push_back(mk(0,1,4'b0000,4'b1000,4'b0,4'd7,16'h0022, 4'b1000,4'b1000,16'h0011,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd7,16'h0,    4'b0000,4'b1000,16'h0022,2'b00));
    // reset right after a req2 read grant: tag lost, req0 wins next
    vecs.push_back(mk(0,1,4'b0000,4'b0100,4'b0,4'd5,16'h0, 4'b0100,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(1,1,4'b0000,4'b0101,4'b0,4'd5,16'h0, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,1,4'b0000,4'b0101,4'b0,4'd5,16'h0, 4'b0001,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h0, 4'b0000,4'b0001,16'h00A5,2'b00));
    // clock enable low for 3 cycles with req1 pending and a read tag held
    vecs.push_back(mk(0,1,4'b0000,4'b0001,4'b0,4'd5,16'h0, 4'b0001,4'b0000,16'h0,2'b01));
    vecs.push_back(mk(0,0,4'b0000,4'b0010,4'b0,4'd5,16'h0, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,0,4'b0000,4'b0010,4'b0,4'd5,16'h0, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,0,4'b0000,4'b0010,4'b0,4'd5,16'h0, 4'b0000,4'b0000,16'h0,2'b00));
    vecs.push_back(mk(0,1,4'b0000,4'b0010,4'b0,4'd5,16'h0, 4'b0010,4'b0001,16'h00A5,2'b01));
    vecs.push_back(mk(0,1,4'b0000,4'b0000,4'b0,4'd5,16'h0, 4'b0000,4'b0010,16'h00A5,2'b00));
  endtask

  // ---------------- random command generator ----------------
  task automatic new_cmd(input int i);
    int kind;
    kind = $urandom_range(0, 3);
    wr[i] = (kind >= 2);
    rd[i] = (kind == 1) || (kind == 3);
    lk[i] = ($urandom_range(0, 2) == 0);
    p_addr[i] = AW'($urandom_range(0, 15));
    p_data[i] = DW'($urandom_range(0, 65535));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    model_reset();
    rst = 1'b1; en = 1'b1; wr = '0; rd = '0; lk = '0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_data[i] = '0; end
    pack();
    fill_table();

    foreach (vecs[n]) begin
      rst = vecs[n].rst; en = vecs[n].en;
      wr = vecs[n].wr; rd = vecs[n].rd; lk = vecs[n].lk;
      for (int i = 0; i < N; i++) begin p_addr[i] = vecs[n].addr; p_data[i] = vecs[n].data; end
      pack();
      @(negedge clk);
      check($sformatf("vec%0d_ack", n), 64'(ack), 64'(vecs[n].e_ack));
      check($sformatf("vec%0d_vld", n), 64'(miso_vld), 64'(vecs[n].e_vld));
      check($sformatf("vec%0d_ram_en", n), 64'({ram_wr, ram_rd}), 64'(vecs[n].e_ram_en));
      if (vecs[n].e_vld != '0)
        check($sformatf("vec%0d_miso", n), 64'(miso), 64'(vecs[n].e_miso));
      @(posedge clk);
      model_update();
      #1;
    end

    // randomized traffic from a fresh reset
    rst = 1'b1; wr = '0; rd = '0; lk = '0; pack();
    @(posedge clk); model_update(); #1;
    rst = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_last_g == i || !(wr[i] | rd[i])) new_cmd(i);
      end
      en = ($urandom_range(0, 9) != 0);
      pack();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
